// File: rtl/ssd_defs.sv
// Shared constants for the calculator result display: active-low segment
// patterns {a,b,c,d,e,f,g}, converter FSM states and digit count.
package ssd_defs;

  localparam int BCD_DIGITS = 5;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_R     = 7'b1111010;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } conv_state_e;

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 16-bit binary to 5 BCD digits, one bit per cycle.
// Done and Bcd are valid combinationally during the final step so the owner can latch them.
module bin2bcd_seq
  import ssd_defs::*;
(
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Start,
  input  logic [15:0]               Bin,
  output logic                      Busy,
  output logic                      Done,
  output logic [4*BCD_DIGITS-1:0]   Bcd
);

  conv_state_e             state_q;
  logic [15:0]             bin_q;
  logic [4*BCD_DIGITS-1:0] work_q;
  logic [4*BCD_DIGITS-1:0] adj_d;
  logic [4*BCD_DIGITS-1:0] work_d;
  logic [3:0]              step_q;
  logic                    busy_q;

  // Add 3 to every nibble of 5 or more, then shift in the next binary MSB.
  always_comb begin
    adj_d = work_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) begin
        adj_d[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      end
    end
    work_d = {adj_d[4*BCD_DIGITS-2:0], bin_q[15]};
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      work_q  <= '0;
      step_q  <= '0;
      busy_q  <= 1'b0;
    end else if (Start) begin
      state_q <= CONV;
      bin_q   <= Bin;
      work_q  <= '0;
      step_q  <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
        end
        CONV: begin
          bin_q  <= {bin_q[14:0], 1'b0};
          work_q <= work_d;
          step_q <= step_q + 4'd1;
          if (step_q == 4'd15) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // A restart on the last step must not publish the abandoned result.
  assign Done = (state_q == CONV) && (step_q == 4'd15) && !Start;
  assign Bcd  = work_d;
  assign Busy = busy_q;

endmodule

// File: rtl/ssd_result_display.sv
// Calculator result display: BCD conversion plus 8-digit active-low scan.
// Define SSD_LZB_EN to blank leading zeros on An4..An1.
module ssd_result_display
  import ssd_defs::*;
#(
  parameter int SCAN_LSB = 17
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] Value,
  input  logic        Load,
  input  logic        Err,
  output logic        Busy,
  output logic [7:0]  An,
  output logic [6:0]  Cath,
  output logic        Dp
);

  logic                    convDone;
  logic [4*BCD_DIGITS-1:0] convBcd;
  logic [4*BCD_DIGITS-1:0] shown_q;
  logic [SCAN_LSB+2:0]     scan_q;
  logic [2:0]              digIdx;
  logic [3:0]              digit;
  logic                    digLit;
  logic [7:0]              an_q;
  logic [7:0]              an_d;
  logic [6:0]              cath_q;
  logic [6:0]              cath_d;

  bin2bcd_seq u_conv (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Load),
    .Bin   (Value),
    .Busy  (Busy),
    .Done  (convDone),
    .Bcd   (convBcd)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      shown_q <= '0;
      scan_q  <= '0;
      an_q    <= 8'hFF;
      cath_q  <= SEG_BLANK;
    end else begin
      if (convDone) begin
        shown_q <= convBcd;
      end
      scan_q <= scan_q + 1'b1;
      an_q   <= an_d;
      cath_q <= cath_d;
    end
  end

  // Digit select, optional leading-zero blanking and segment encoding.
  always_comb begin
    digIdx = scan_q[SCAN_LSB+2:SCAN_LSB];
    digit  = 4'd0;
    digLit = 1'b0;
    case (digIdx)
      3'd0: begin digit = shown_q[3:0];   digLit = 1'b1; end
`ifdef SSD_LZB_EN
      3'd1: begin digit = shown_q[7:4];   digLit = |shown_q[19:4];  end
      3'd2: begin digit = shown_q[11:8];  digLit = |shown_q[19:8];  end
      3'd3: begin digit = shown_q[15:12]; digLit = |shown_q[19:12]; end
      3'd4: begin digit = shown_q[19:16]; digLit = |shown_q[19:16]; end
`else
      3'd1: begin digit = shown_q[7:4];   digLit = 1'b1; end
      3'd2: begin digit = shown_q[11:8];  digLit = 1'b1; end
      3'd3: begin digit = shown_q[15:12]; digLit = 1'b1; end
      3'd4: begin digit = shown_q[19:16]; digLit = 1'b1; end
`endif
      default: begin digit = 4'd0; digLit = 1'b0; end
    endcase

    if (Err) begin
      case (digIdx)
        3'd2:      cath_d = SEG_E;
        3'd1, 3'd0: cath_d = SEG_R;
        default:   cath_d = SEG_BLANK;
      endcase
    end else if (digLit) begin
      cath_d = seg_encode(digit);
    end else begin
      cath_d = SEG_BLANK;
    end

    an_d = ~(8'd1 << digIdx);
  end

  assign An   = an_q;
  assign Cath = cath_q;
  assign Dp   = 1'b1;

endmodule
